// File: rtl/axi_lite_xbar_pkg.sv
// Shared constants, FSM encodings and the decode helper for the AXI-Lite
// crossbar between the CPU memory arbiter and its peripherals.
package axi_lite_xbar_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int NSLV      = 3;
  // The internal error slave sits one past the last real slave in the select vector
  localparam int ERR_IDX   = NSLV;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FWD  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_FWD  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  typedef logic [NSLV:0] sel_t;

  function automatic logic addr_hit(input logic [CPU_WIDTH-1:0] addr,
                                    input logic [CPU_WIDTH-1:0] base,
                                    input logic [CPU_WIDTH-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/axi_lite_xbar_if.sv
// AXI-Lite bundle; N > 1 packs N buses side by side, bus k in bits [k*w +: w].
interface axi_lite_xbar_if
  import axi_lite_xbar_pkg::*;
#(
  parameter int N = 1
) ();

  logic [N*CPU_WIDTH-1:0]   awaddr;
  logic [N-1:0]             awvalid;
  logic [N-1:0]             awready;
  logic [N*CPU_WIDTH-1:0]   wdata;
  logic [N*CPU_WIDTH/8-1:0] wstrb;
  logic [N-1:0]             wvalid;
  logic [N-1:0]             wready;
  logic [N*2-1:0]           bresp;
  logic [N-1:0]             bvalid;
  logic [N-1:0]             bready;
  logic [N*CPU_WIDTH-1:0]   araddr;
  logic [N-1:0]             arvalid;
  logic [N-1:0]             arready;
  logic [N*CPU_WIDTH-1:0]   rdata;
  logic [N*2-1:0]           rresp;
  logic [N-1:0]             rvalid;
  logic [N-1:0]             rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_xbar_addr_dec.sv
// Combinational address decoder: one-hot {err, s2, s1, s0}, lower slaves win.
module axi_lite_xbar_addr_dec
  import axi_lite_xbar_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'hA000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
  parameter logic [31:0] S2_BASE = 32'hA000_1000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_F000
) (
  input  logic [CPU_WIDTH-1:0] addr,
  output sel_t                 sel
);

  always_comb begin
    sel = '0;
    if (addr_hit(addr, S0_BASE, S0_MASK))      sel[0]       = 1'b1;
    else if (addr_hit(addr, S1_BASE, S1_MASK)) sel[1]       = 1'b1;
    else if (addr_hit(addr, S2_BASE, S2_MASK)) sel[2]       = 1'b1;
    else                                       sel[ERR_IDX] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-master to 3-slave AXI-Lite crossbar; independent write and read FSMs,
// one outstanding transaction each, unmapped addresses answered with DECERR.
module axi_lite_xbar
  import axi_lite_xbar_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'hA000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
  parameter logic [31:0] S2_BASE = 32'hA000_1000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_F000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  axi_lite_xbar_if.slave  s,
  axi_lite_xbar_if.master m
);

  logic [1:0] w_state, r_state;
  sel_t       wsel, rsel, aw_dec, ar_dec;
  logic       aw_done, w_done;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  axi_lite_xbar_addr_dec #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE),
    .S1_MASK(S1_MASK), .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
  ) u_aw_dec (.addr(s.awaddr), .sel(aw_dec));

  axi_lite_xbar_addr_dec #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE),
    .S1_MASK(S1_MASK), .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
  ) u_ar_dec (.addr(s.araddr), .sel(ar_dec));

  // Payloads go to every slave; only the handshake signals are steered
  assign m.awaddr = {NSLV{s.awaddr}};
  assign m.wdata  = {NSLV{s.wdata}};
  assign m.wstrb  = {NSLV{s.wstrb}};
  assign m.araddr = {NSLV{s.araddr}};

  assign aw_hs = s.awvalid & s.awready;
  assign w_hs  = s.wvalid  & s.wready;
  assign b_hs  = s.bvalid  & s.bready;
  assign ar_hs = s.arvalid & s.arready;
  assign r_hs  = s.rvalid  & s.rready;

  always_comb begin
    m.awvalid = '0;
    m.wvalid  = '0;
    m.bready  = '0;
    s.awready = 1'b0;
    s.wready  = 1'b0;
    s.bvalid  = 1'b0;
    s.bresp   = AXI_RESP_OKAY;
    if (w_state == W_FWD) begin
      if (wsel[ERR_IDX]) begin
        s.awready = !aw_done;
        s.wready  = !w_done;
      end
      for (int k = 0; k < NSLV; k++) begin
        if (wsel[k]) begin
          m.awvalid[k] = s.awvalid & !aw_done;
          m.wvalid[k]  = s.wvalid  & !w_done;
          s.awready    = m.awready[k] & !aw_done;
          s.wready     = m.wready[k]  & !w_done;
        end
      end
    end else if (w_state == W_RESP) begin
      if (wsel[ERR_IDX]) begin
        s.bvalid = 1'b1;
        s.bresp  = AXI_RESP_DECERR;
      end
      for (int k = 0; k < NSLV; k++) begin
        if (wsel[k]) begin
          s.bvalid    = m.bvalid[k];
          s.bresp     = m.bresp[k*2 +: 2];
          m.bready[k] = s.bready;
        end
      end
    end
  end

  always_comb begin
    m.arvalid = '0;
    m.rready  = '0;
    s.arready = 1'b0;
    s.rvalid  = 1'b0;
    s.rresp   = AXI_RESP_OKAY;
    s.rdata   = '0;
    if (r_state == R_FWD) begin
      if (rsel[ERR_IDX]) s.arready = 1'b1;
      for (int k = 0; k < NSLV; k++) begin
        if (rsel[k]) begin
          m.arvalid[k] = s.arvalid;
          s.arready    = m.arready[k];
        end
      end
    end else if (r_state == R_RESP) begin
      if (rsel[ERR_IDX]) begin
        s.rvalid = 1'b1;
        s.rresp  = AXI_RESP_DECERR;
      end
      for (int k = 0; k < NSLV; k++) begin
        if (rsel[k]) begin
          s.rvalid    = m.rvalid[k];
          s.rresp     = m.rresp[k*2 +: 2];
          s.rdata     = m.rdata[k*CPU_WIDTH +: CPU_WIDTH];
          m.rready[k] = s.rready;
        end
      end
    end
  end

  // AW and W may complete in different cycles; the done flags stop re-issuing either one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state <= W_IDLE;
      wsel    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s.awvalid && s.wvalid) begin
          wsel    <= aw_dec;
          w_state <= W_FWD;
        end
        W_FWD: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
        end
        W_RESP: if (b_hs) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= R_IDLE;
      rsel    <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s.arvalid) begin
          rsel    <= ar_dec;
          r_state <= R_FWD;
        end
        R_FWD:   if (ar_hs) r_state <= R_RESP;
        R_RESP:  if (r_hs)  r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
